// File: rtl/dmem_access_ctrl_pkg.sv
// Shared constants for the M-stage data-access controller: ALU control codes,
// bus size codes, FSM state encoding and the latched request-lane struct.
package dmem_access_ctrl_pkg;

    localparam logic [5:0] ALU_LB  = 6'h20;
    localparam logic [5:0] ALU_LH  = 6'h21;
    localparam logic [5:0] ALU_LW  = 6'h23;
    localparam logic [5:0] ALU_LBU = 6'h24;
    localparam logic [5:0] ALU_LHU = 6'h25;
    localparam logic [5:0] ALU_SB  = 6'h28;
    localparam logic [5:0] ALU_SH  = 6'h29;
    localparam logic [5:0] ALU_SW  = 6'h2B;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        DMEM_IDLE  = 3'd0,
        DMEM_REQ   = 3'd1,
        DMEM_WAIT  = 3'd2,
        DMEM_DRAIN = 3'd3,
        DMEM_DONE  = 3'd4
    } dmem_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dmem_lane_t;

    // Unknown control codes fall through to word size.
    function automatic logic [1:0] size_of(input logic [5:0] ctrl);
        case (ctrl)
            ALU_LB, ALU_LBU, ALU_SB: size_of = SIZE_BYTE;
            ALU_LH, ALU_LHU, ALU_SH: size_of = SIZE_HALF;
            default:                 size_of = SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// SRAM-like data bus: one request channel (req/addr_ok) and one response
// channel (data_ok/rdata), shared by reads and writes.
interface dmem_access_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [3:0]    data_wstrb;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl_addr_align_chk.sv
// Combinational decode of a load/store: misalignment flags, bus size,
// big-endian byte strobes and lane-replicated store data.
module addr_align_chk
    import dmem_access_ctrl_pkg::*;
(
    input  logic        i_memen,
    input  logic        i_memwrite,
    input  logic [5:0]  i_alucontrol,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic        o_laddrerr,
    output logic        o_saddrerr,
    output logic [1:0]  o_size,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata
);
    logic w_mis;

    // Byte lane 0 is the most significant byte, so strobes shift right with the address.
    always_comb begin
        o_size  = size_of(i_alucontrol);
        w_mis   = 1'b0;
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        case (o_size)
            SIZE_BYTE: begin
                o_wstrb = 4'b1000 >> i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SIZE_HALF: begin
                w_mis   = i_addr_lo[0];
                o_wstrb = 4'b1100 >> i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: w_mis = |i_addr_lo;
        endcase
        if (!i_memwrite) o_wstrb = 4'b0000;
    end

    assign o_laddrerr = i_memen & ~i_memwrite & w_mis;
    assign o_saddrerr = i_memen &  i_memwrite & w_mis;
endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage data-access controller: issues one bus transaction per load/store,
// stalls M until the response arrives and registers the raw read word.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memenM,
    input  logic          memwriteM,
    input  logic [5:0]    alucontrolM,
    input  logic [AW-1:0] aluoutM,
    input  logic [DW-1:0] writedataM,
    input  logic          flushM,
    input  logic          pipe_holdM,
    output logic          laddrerrM,
    output logic          saddrerrM,
    output logic          stallM,
    output logic [DW-1:0] lwresultM,
    dmem_access_ctrl_if.master dbus
);
    dmem_state_e   r_state;
    logic          r_kill;
    dmem_lane_t    r_lane;
    logic [AW-1:0] r_addr;

    logic          w_access, w_issue, w_req;
    logic [1:0]    w_size;
    logic [3:0]    w_wstrb;
    logic [31:0]   w_wdata;
    dmem_lane_t    w_lane, w_sel;

    addr_align_chk u_align (
        .i_memen      (memenM),
        .i_memwrite   (memwriteM),
        .i_alucontrol (alucontrolM),
        .i_addr_lo    (aluoutM[1:0]),
        .i_wdata      (writedataM),
        .o_laddrerr   (laddrerrM),
        .o_saddrerr   (saddrerrM),
        .o_size       (w_size),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata)
    );

    assign w_access = memenM & ~laddrerrM & ~saddrerrM & ~flushM;
    assign w_issue  = (r_state == DMEM_IDLE) & w_access;
    assign w_req    = w_issue | (r_state == DMEM_REQ);
    assign w_lane   = '{wr: memwriteM, size: w_size, wstrb: w_wstrb, wdata: w_wdata};
    // The issue cycle drives the live decode; later cycles replay the latched copy.
    assign w_sel    = w_issue ? w_lane : r_lane;

    assign dbus.data_req   = w_req;
    assign dbus.data_wr    = w_req & w_sel.wr;
    assign dbus.data_size  = w_sel.size;
    assign dbus.data_addr  = w_issue ? aluoutM : r_addr;
    assign dbus.data_wdata = w_sel.wdata;
    assign dbus.data_wstrb = w_req ? w_sel.wstrb : 4'b0000;

    assign stallM = w_issue | (r_state == DMEM_REQ) | (r_state == DMEM_WAIT)
                  | (r_state == DMEM_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DMEM_IDLE;
            r_kill    <= 1'b0;
            r_lane    <= '0;
            r_addr    <= '0;
            lwresultM <= '0;
        end else begin
            case (r_state)
                DMEM_IDLE: if (w_access) begin
                    r_lane <= w_lane;
                    r_addr <= aluoutM;
                    if (dbus.data_addr_ok && dbus.data_data_ok) begin
                        r_state <= DMEM_DONE;
                        if (!memwriteM) lwresultM <= dbus.data_rdata;
                    end else if (dbus.data_addr_ok) begin
                        r_state <= DMEM_WAIT;
                    end else begin
                        r_state <= DMEM_REQ;
                    end
                end
                // A request cannot be withdrawn; a flush seen here is remembered
                // until the slave accepts, then the response is dropped.
                DMEM_REQ: begin
                    if (dbus.data_addr_ok) begin
                        r_kill <= 1'b0;
                        if (flushM || r_kill) begin
                            r_state <= dbus.data_data_ok ? DMEM_IDLE : DMEM_DRAIN;
                        end else if (dbus.data_data_ok) begin
                            r_state <= DMEM_DONE;
                            if (!r_lane.wr) lwresultM <= dbus.data_rdata;
                        end else begin
                            r_state <= DMEM_WAIT;
                        end
                    end else if (flushM) begin
                        r_kill <= 1'b1;
                    end
                end
                DMEM_WAIT: begin
                    if (dbus.data_data_ok) begin
                        if (flushM) begin
                            r_state <= DMEM_IDLE;
                        end else begin
                            r_state <= DMEM_DONE;
                            if (!r_lane.wr) lwresultM <= dbus.data_rdata;
                        end
                    end else if (flushM) begin
                        r_state <= DMEM_DRAIN;
                    end
                end
                DMEM_DRAIN: if (dbus.data_data_ok) r_state <= DMEM_IDLE;
                DMEM_DONE:  if (!pipe_holdM || flushM) r_state <= DMEM_IDLE;
                default:    r_state <= DMEM_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized and directed bench for dmem_access_ctrl; a cycle-level bus slave
// is played from each task and checked against arithmetic expectations.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memenM = 1'b0, memwriteM = 1'b0, flushM = 1'b0, pipe_holdM = 1'b0;
    logic [5:0]  alucontrolM = ALU_LW;
    logic [31:0] aluoutM = '0, writedataM = '0;
    logic        laddrerrM, saddrerrM, stallM;
    logic [31:0] lwresultM;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_lw   = '0;
    logic [5:0]  ops [8]  = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_SB, ALU_SH, ALU_SW};

    dmem_access_ctrl_if #(.AW(32), .DW(32)) dbus ();

    dmem_access_ctrl #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM),
        .alucontrolM(alucontrolM), .aluoutM(aluoutM), .writedataM(writedataM),
        .flushM(flushM), .pipe_holdM(pipe_holdM), .laddrerrM(laddrerrM),
        .saddrerrM(saddrerrM), .stallM(stallM), .lwresultM(lwresultM), .dbus(dbus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int nbytes(input logic [5:0] op);
        case (op)
            ALU_LB, ALU_LBU, ALU_SB: return 1;
            ALU_LH, ALU_LHU, ALU_SH: return 2;
            default:                 return 4;
        endcase
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
        memenM = 1'b1; memwriteM = is_store(op); alucontrolM = op;
        aluoutM = addr; writedataM = wd;
    endtask

    // One complete access: slave accepts after al cycles, responds dl cycles later;
    // M is then held in DONE for `hold` cycles.
    task automatic run_txn(input string name, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int al, input int dl, input int hold);
        int          nb, a;
        bit          st;
        logic [1:0]  e_size;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        nb = nbytes(op); a = int'(addr % 4); st = is_store(op);
        e_size  = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
        e_strb  = !st ? 4'h0 : (nb == 4) ? 4'hF : (nb == 2) ? 4'(3 << (2 - a)) : 4'(1 << (3 - a));
        e_wdata = (nb == 1) ? 32'(wd[7:0]) * 32'h01010101 :
                  (nb == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
        set_op(op, addr, wd);
        flushM = 1'b0; pipe_holdM = 1'b0;
        for (int k = 0; k <= al + dl; k++) begin
            dbus.data_addr_ok = (k == al);
            dbus.data_data_ok = (k == al + dl);
            dbus.data_rdata   = dbus.data_data_ok ? rd : $urandom;
            #2;
            n_checks++;
            if (stallM !== 1'b1) begin n_fail++; $display("FAIL %s stall k=%0d: got %b want 1", name, k, stallM); end
            n_checks++;
            if (dbus.data_req !== (k <= al)) begin n_fail++; $display("FAIL %s req k=%0d: got %b want %b", name, k, dbus.data_req, k <= al); end
            n_checks++;
            if (lwresultM !== exp_lw) begin n_fail++; $display("FAIL %s lw_busy k=%0d: got %h want %h", name, k, lwresultM, exp_lw); end
            if (k <= al) begin
                n_checks++;
                if ({dbus.data_wr, dbus.data_size, dbus.data_addr, dbus.data_wstrb} !== {st, e_size, addr, e_strb}) begin
                    n_fail++;
                    $display("FAIL %s fields k=%0d: got wr=%b sz=%0d a=%h strb=%b want wr=%b sz=%0d a=%h strb=%b",
                             name, k, dbus.data_wr, dbus.data_size, dbus.data_addr, dbus.data_wstrb, st, e_size, addr, e_strb);
                end
                if (st) begin
                    n_checks++;
                    if (dbus.data_wdata !== e_wdata) begin n_fail++; $display("FAIL %s wdata k=%0d: got %h want %h", name, k, dbus.data_wdata, e_wdata); end
                end
            end
            next_cycle();
        end
        dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b0;
        if (!st) exp_lw = rd;
        for (int h = 0; h <= hold; h++) begin
            pipe_holdM = (h < hold);
            dbus.data_rdata = $urandom;
            #2;
            n_checks++;
            if ({stallM, dbus.data_req} !== 2'b00) begin n_fail++; $display("FAIL %s done h=%0d: got stall=%b req=%b want 0 0", name, h, stallM, dbus.data_req); end
            n_checks++;
            if (lwresultM !== exp_lw) begin n_fail++; $display("FAIL %s lw_done h=%0d: got %h want %h", name, h, lwresultM, exp_lw); end
            next_cycle();
        end
        pipe_holdM = 1'b0; memenM = 1'b0;
    endtask

    task automatic test_reset();
        dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b0; dbus.data_rdata = '0;
        #2;
        n_checks++;
        if ({stallM, dbus.data_req, dbus.data_wr, dbus.data_wstrb} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outs: got stall=%b req=%b wr=%b strb=%b want all 0", stallM, dbus.data_req, dbus.data_wr, dbus.data_wstrb);
        end
        n_checks++;
        if (lwresultM !== 32'h0) begin n_fail++; $display("FAIL reset_lw: got %h want 0", lwresultM); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_align();
        logic [5:0]  op;
        logic [31:0] addr;
        bit          en, mis, st;
        for (int i = 0; i < 26; i++) begin
            if (i == 0)      begin op = ALU_LH; addr = 32'h101; en = 1'b1; end
            else if (i == 1) begin op = ALU_SW; addr = 32'h102; en = 1'b1; end
            else begin op = ops[$urandom_range(0, 7)]; addr = $urandom; en = ($urandom_range(0, 3) != 0); end
            st  = is_store(op);
            mis = (addr % nbytes(op)) != 0;
            set_op(op, addr, $urandom); memenM = en;
            #1;
            n_checks++;
            if ({laddrerrM, saddrerrM} !== {en & mis & !st, en & mis & st}) begin
                n_fail++; $display("FAIL align op=%h a=%h en=%b: got l=%b s=%b want l=%b s=%b", op, addr, en, laddrerrM, saddrerrM, en & mis & !st, en & mis & st);
            end
            n_checks++;
            if ({dbus.data_req, stallM} !== {2{en & !mis}}) begin
                n_fail++; $display("FAIL align_req op=%h a=%h: got req=%b stall=%b want %b", op, addr, dbus.data_req, stallM, en & !mis);
            end
            memenM = 1'b0;
            next_cycle();
        end
    endtask

    task automatic test_flush_wait();
        logic [31:0] rd;
        set_op(ALU_LW, 32'h300, '0); dbus.data_addr_ok = 1'b1;
        next_cycle();                                     // WAIT
        dbus.data_addr_ok = 1'b0; flushM = 1'b1; memenM = 1'b0;
        next_cycle();                                     // DRAIN; next load waits
        flushM = 1'b0; set_op(ALU_LW, 32'h304, '0);
        for (int k = 0; k < 2; k++) begin
            dbus.data_data_ok = (k == 1); dbus.data_rdata = 32'hDEADBEEF;
            #2;
            n_checks++;
            if ({stallM, dbus.data_req} !== 2'b10) begin n_fail++; $display("FAIL drain k=%0d: got stall=%b req=%b want 1 0", k, stallM, dbus.data_req); end
            n_checks++;
            if (lwresultM !== exp_lw) begin n_fail++; $display("FAIL drain_lw k=%0d: got %h want %h", k, lwresultM, exp_lw); end
            next_cycle();
        end
        dbus.data_data_ok = 1'b0;
        rd = $urandom;
        run_txn("after_drain", ALU_LW, 32'h304, '0, rd, 0, 0, 0);
    endtask

    task automatic test_flush_req();
        set_op(ALU_SH, 32'h2, 32'h1234);
        next_cycle();                                     // REQ
        flushM = 1'b1; memenM = 1'b0; aluoutM = $urandom; writedataM = $urandom;
        for (int k = 0; k < 2; k++) begin
            dbus.data_addr_ok = (k == 1);
            #2;
            n_checks++;
            if ({dbus.data_req, stallM, dbus.data_addr, dbus.data_wstrb, dbus.data_wdata} !== {2'b11, 32'h2, 4'b0011, 32'h12341234}) begin
                n_fail++; $display("FAIL flush_req_hold k=%0d: got req=%b a=%h strb=%b wd=%h want 1 00000002 0011 12341234",
                                   k, dbus.data_req, dbus.data_addr, dbus.data_wstrb, dbus.data_wdata);
            end
            next_cycle();
            flushM = 1'b0;
        end
        dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b1;
        #2;
        n_checks++;
        if ({stallM, dbus.data_req} !== 2'b10) begin n_fail++; $display("FAIL flush_req_drain: got stall=%b req=%b want 1 0", stallM, dbus.data_req); end
        next_cycle();
        dbus.data_data_ok = 1'b0;
        #2;
        n_checks++;
        if ({stallM, dbus.data_req, lwresultM} !== {2'b00, exp_lw}) begin
            n_fail++; $display("FAIL flush_req_idle: got stall=%b req=%b lw=%h want 0 0 %h", stallM, dbus.data_req, lwresultM, exp_lw);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [5:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            op   = ops[$urandom_range(0, 7)];
            addr = $urandom & ~(32'(nbytes(op)) - 32'd1);
            run_txn("random", op, addr, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                #2;
                n_checks++;
                if ({stallM, dbus.data_req} !== 2'b00) begin n_fail++; $display("FAIL random_gap %0d: got stall=%b req=%b want 0 0", i, stallM, dbus.data_req); end
                next_cycle();
            end
        end
    endtask

    task automatic test_rst_mid();
        set_op(ALU_LW, 32'h40, '0);
        next_cycle();                                     // REQ
        #2;
        n_checks++;
        if ({dbus.data_req, stallM} !== 2'b11) begin n_fail++; $display("FAIL rst_mid_req: got req=%b stall=%b want 1 1", dbus.data_req, stallM); end
        #1;
        rst = 1'b1; memenM = 1'b0;
        #1;
        exp_lw = '0;
        n_checks++;
        if ({dbus.data_req, stallM, lwresultM} !== 34'b0) begin
            n_fail++; $display("FAIL rst_mid: got req=%b stall=%b lw=%h want 0 0 0", dbus.data_req, stallM, lwresultM);
        end
        next_cycle();
        rst = 1'b0;
        run_txn("post_rst", ALU_LBU, 32'h41, '0, 32'hCAFEF00D, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        run_txn("lw_single", ALU_LW, 32'h100, '0, 32'h11223344, 0, 0, 0);
        run_txn("sb_slow", ALU_SB, 32'h203, 32'hAB, $urandom, 3, 2, 0);
        test_align();
        test_flush_wait();
        test_flush_req();
        run_txn("done_hold", ALU_LW, 32'h500, '0, 32'h5A5AA5A5, 1, 1, 3);
        test_random();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
